// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction_memory combinationally, resolves JUMP
// locally, accepts downstream branch redirects and parks in HALT rather than leave the image.
module instruction_fetch #(
  parameter int unsigned                ADDR_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]      LAST_ADDR  = 26,
  parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0,
  parameter logic [5:0]                 JUMP_OP    = 6'b010101
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  valid_out,
  output logic                  halted,
  output logic                  state_out
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic [ADDR_WIDTH-1:0]   pc_out_q;
  logic                    valid_q;
  logic                    halted_q;
  logic [ADDR_WIDTH-1:0]   next_pc_d;
  logic                    is_jump;

  assign is_jump = (data_in[31:26] == JUMP_OP);

  always_comb begin
    next_pc_d = pc_q + ADDR_WIDTH'(1);
    if (is_jump) next_pc_d = {{(ADDR_WIDTH-26){1'b0}}, data_in[25:0]};
  end

  // Handshake: valid_out qualifies instr_out/pc_out; stall is the downstream
  // not-ready and freezes the PC and the IF/ID register. branch_taken wins over stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (branch_taken) begin
        instr_q <= '0;
        valid_q <= 1'b0;
        if (branch_target <= LAST_ADDR) pc_q <= branch_target;
        else                            state_q <= HALT;
      end else if (!stall) begin
        instr_q  <= data_in;
        pc_out_q <= pc_q;
        valid_q  <= 1'b1;
        // An out-of-range successor leaves the PC on its last legal value.
        if (next_pc_d <= LAST_ADDR) pc_q <= next_pc_d;
        else                        state_q <= HALT;
      end
    end else begin
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b1;
    end
  end

  assign addr_out  = pc_q;
  assign instr_out = instr_q;
  assign pc_out    = pc_out_q;
  assign valid_out = valid_q;
  assign halted    = halted_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized stall/branch/reset
// traffic, all checked every cycle against a behavioural fetch model.
module tb_instruction_fetch;

  localparam logic [5:0] JOP  = 6'b010101;
  localparam int         LAST = 26;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] addr_out, data_in, branch_target, instr_out, pc_out;
  logic        stall = 1'b0, branch_taken = 1'b0;
  logic        valid_out, halted, state_out;
  logic [31:0] mem [64];

  assign data_in = (addr_out < 32'd64) ? mem[addr_out[5:0]] : 32'hDEAD_BEEF;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .addr_out(addr_out), .data_in(data_in),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out),
    .halted(halted), .state_out(state_out)
  );

  // behavioural model of the fetch stage
  int unsigned m_pc, m_pc_out;
  logic [31:0] m_instr;
  bit          m_valid, m_halted, m_stopped;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 0; m_pc_out = 0; m_instr = '0;
    m_valid = 0; m_halted = 0; m_stopped = 0;
  endtask

  task automatic model_step();
    logic [31:0]  w;
    int unsigned  nxt;
    if (m_stopped) begin
      m_valid = 0; m_instr = '0; m_halted = 1;
    end else if (branch_taken) begin
      m_valid = 0; m_instr = '0;
      if (branch_target <= LAST) m_pc = branch_target;
      else                       m_stopped = 1;
    end else if (!stall) begin
      w = mem[m_pc];
      m_instr = w; m_pc_out = m_pc; m_valid = 1;
      nxt = (w[31:26] == JOP) ? int'(w[25:0]) : m_pc + 1;
      if (nxt <= LAST) m_pc = nxt;
      else             m_stopped = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".addr"},   addr_out,  m_pc);
    check({tag, ".instr"},  instr_out, m_instr);
    check({tag, ".pc_out"}, pc_out,    m_pc_out);
    check({tag, ".valid"},  {31'b0, valid_out}, {31'b0, m_valid});
    check({tag, ".halted"}, {31'b0, halted},    {31'b0, m_halted});
    check({tag, ".state"},  {31'b0, state_out}, {31'b0, m_stopped});
    check({tag, ".range"},  {31'b0, addr_out <= LAST}, 32'd1);
  endtask

  // driver: apply inputs, advance one clock, compare on the falling edge
  task automatic tick(input bit st, input bit br, input logic [31:0] tgt);
    stall = st; branch_taken = br; branch_target = tgt;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all("cyc");
  endtask

  // reset pulse placed strictly between clock edges
  task automatic async_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    compare_all("async_rst");
    #1 reset = 1'b0;
  endtask

  task automatic load_image();
    logic [5:0] op;
    for (int i = 0; i < 64; i++) begin
      op = 6'($urandom_range(0, 63));
      if (op == JOP) op = 6'b0;
      mem[i] = {op, 26'($urandom)};
    end
    mem[2] = {JOP, 26'd6};
  endtask

  initial begin
    load_image();
    branch_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    check("lit.reset_addr",  addr_out, 32'd0);
    check("lit.reset_valid", {31'b0, valid_out}, 32'd0);
    reset = 1'b0;

    // free-run through the image, JUMP at 2 goes to 6
    tick(0, 0, 0);
    check("lit.addr1",   addr_out, 32'd1);
    check("lit.pcout0",  pc_out,   32'd0);
    check("lit.instr0",  instr_out, mem[0]);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("lit.jump_addr6", addr_out, 32'd6);
    check("lit.jump_pcout", pc_out,   32'd2);
    check("lit.jump_valid", {31'b0, valid_out}, 32'd1);
    repeat (21) tick(0, 0, 0);
    check("lit.last_pcout", pc_out, 32'd26);
    check("lit.last_valid", {31'b0, valid_out}, 32'd1);
    check("lit.last_halt0", {31'b0, halted}, 32'd0);
    tick(0, 0, 0);
    check("lit.halted",     {31'b0, halted}, 32'd1);
    check("lit.halt_valid", {31'b0, valid_out}, 32'd0);
    repeat (10) tick($urandom_range(0, 1), $urandom_range(0, 1), 32'd3);
    check("lit.halt_addr", addr_out, 32'd26);

    // reset while halted, then restart from 0
    async_reset();
    tick(0, 0, 0);
    check("lit.restart", addr_out, 32'd1);

    // stall 3 cycles at PC=4
    tick(0, 1, 32'd3);
    tick(0, 0, 0);
    repeat (3) tick(1, 0, 0);
    check("lit.stall_addr",  addr_out, 32'd4);
    check("lit.stall_pcout", pc_out,   32'd3);
    tick(0, 0, 0);
    check("lit.unstall_addr", addr_out, 32'd5);

    // branch overrides stall at PC=9
    tick(0, 1, 32'd9);
    tick(1, 1, 32'd3);
    check("lit.br_addr",  addr_out, 32'd3);
    check("lit.br_instr", instr_out, 32'd0);
    tick(0, 0, 0);
    check("lit.br_pcout", pc_out, 32'd3);
    check("lit.br_instr3", instr_out, mem[3]);

    // reset while stalled at PC=12
    tick(0, 1, 32'd12);
    tick(1, 0, 0);
    stall = 1'b1;
    async_reset();
    tick(0, 0, 0);
    check("lit.rst_stall_addr", addr_out, 32'd1);

    // out-of-range branch target
    tick(0, 1, 32'd30);
    check("lit.oob_addr", addr_out, 32'd1);
    tick(0, 0, 0);
    check("lit.oob_halted", {31'b0, halted}, 32'd1);

    // randomized traffic; some images contain out-of-range and looping jumps
    for (int ph = 0; ph < 3; ph++) begin
      load_image();
      if (ph >= 1) mem[15] = {JOP, 26'd40};
      if (ph == 2) mem[20] = {JOP, 26'd8};
      async_reset();
      for (int n = 0; n < 700; n++) begin
        if ($urandom_range(0, 99) < 3) async_reset();
        tick($urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 8,
             32'($urandom_range(0, 31)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of the RISC CPU. Owns the program counter, drives the word address into instruction_memory, samples the combinational instruction word it returns, and registers it with its PC into the IF/ID pipeline register. Resolves JUMP locally. Accepts BRA redirects from downstream. Never presents an out-of-range address to the memory; it enters a terminal HALT state instead.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address (word-indexed)
DATA_WIDTH, 32, instruction word width
LAST_ADDR, 26, highest populated instruction address; fetch never addresses beyond it
RESET_PC, 0, PC value loaded on reset
JUMP_OP, 6'b010101, opcode in bits [31:26] that fetch resolves as an absolute jump

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
addr_out  output  ADDR_WIDTH  word address to instruction_memory addr_in; equals PC register
data_in  input  DATA_WIDTH  instruction word from instruction_memory data_out (combinational, same cycle)
stall  input  1  downstream cannot accept; hold IF/ID and PC
branch_taken  input  1  single-cycle pulse: BRA resolved taken, redirect and flush
branch_target  input  ADDR_WIDTH  word address for the redirect; valid with branch_taken
instr_out  output  DATA_WIDTH  registered instruction to decode
pc_out  output  ADDR_WIDTH  address instr_out was fetched from
valid_out  output  1  instr_out/pc_out hold a real instruction
halted  output  1  fetch stopped on range overflow

Behaviour:
- Reset is asynchronous and active-high. Affected outputs are not clock-gated.
- Reset values: PC=RESET_PC (so addr_out=RESET_PC), instr_out=0 (NOP encoding), pc_out=0, valid_out=0, halted=0, state=RUN.
- States: RUN and HALT. Exit from HALT is by reset only.
- addr_out is driven directly from the PC register. The memory read completes within the same cycle, and data_in is sampled at the next rising edge.
- Every edge in RUN evaluates the following, in priority order:
  1. branch_taken=1 (overrides stall): instr_out<=0, valid_out<=0, pc_out held. If branch_target<=LAST_ADDR then PC<=branch_target, else go to HALT.
  2. stall=1: PC, instr_out, pc_out and valid_out all hold. The JUMP check is not applied while stalled.
  3. Otherwise: instr_out<=data_in, pc_out<=PC, valid_out<=1. next_pc = {6'b0, data_in[25:0]} if data_in[31:26]==JUMP_OP, else PC+1.
     - If next_pc<=LAST_ADDR then PC<=next_pc.
     - Else PC holds and state goes to HALT on this same edge. The last instruction is still delivered with valid_out=1.
- JUMP has zero-bubble redirect. The JUMP word itself is forwarded to decode with valid_out=1; decode treats it as a no-op.
- First edge in HALT: valid_out<=0, instr_out<=0, halted<=1. On later edges these hold.
  - PC stays at its last legal value, so addr_out<=LAST_ADDR always.
  - stall and branch_taken are ignored in HALT.
- PC arithmetic is unsigned ADDR_WIDTH. PC+1 wrap-around cannot occur because the LAST_ADDR check precedes any load.
- Reset asserted mid-operation, including mid-stall or in HALT, forces the reset values immediately. The first fetch after release is from RESET_PC.
- No X on any output after reset. data_in is only consumed when state=RUN and stall=0.

Test Plan:
- Reset then free-run against the standard instruction_memory image:
  - addr_out sequence is 0,1,2,6,7,…,26.
  - pc_out trails it by one cycle.
  - The JUMP at address 2 yields PC=6 on the next edge with no bubble.
- Straight-line fetch to the end: after the word at 26 (BRA) is captured with valid_out=1, halted=1 one cycle later, valid_out=0, and addr_out stays 26 for 10+ cycles.
- Stall held for 3 cycles at PC=4:
  - addr_out=4, instr_out/pc_out unchanged, valid_out unchanged.
  - After release, PC advances to 5 on the first free edge.
- branch_taken=1 with branch_target=3 while stall=1 at PC=9: next edge gives PC=3, valid_out=0, instr_out=0. The following edge delivers the STORE word with pc_out=3.
- branch_taken=1 with branch_target=30 from RUN: halted=1, valid_out=0, addr_out stays at its pre-branch value (<=26), and no address >26 ever appears.
- Async reset pulsed between clock edges while halted, and again while stalled at PC=12: outputs return to reset values immediately. Fetch restarts at address 0 on the first edge after deassertion.
